// File: rtl/div_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// Master drives the request; slave returns the result and flags.
interface div_if #(
  parameter int WIDTH = 24
);
  logic                 start;
  logic [2*WIDTH-1:0]   a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic                 busy;
  logic                 done;
  logic                 dz;
  logic                 ovf;
  logic                 sticky;

  modport master (
    output start, a, b,
    input  q, r, busy, done, dz, ovf, sticky
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, dz, ovf, sticky
  );
endinterface

// File: rtl/div_48by24_seq.sv
// Radix-2 restoring 2W/W unsigned divider, one quotient bit per clock.
// Optional DIV_STICKY_EN adds a registered remainder-non-zero flag.
module div_48by24_seq #(
  parameter int WIDTH = 24
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLAG,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_hi, a_lo;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, qreg_nx;
  logic             load, fin;

  assign a_hi = bus.a[2*WIDTH-1:WIDTH];
  assign a_lo = bus.a[WIDTH-1:0];

  // Shifted partial remainder carries one extra bit out of the top.
  always_comb begin
    shifted = {rem_q, qreg_q[WIDTH-1]};
    ge      = shifted >= {1'b0, b_q};
    rem_nx  = ge ? WIDTH'(shifted - {1'b0, b_q})
                 : shifted[WIDTH-1:0];
    qreg_nx = {qreg_q[WIDTH-2:0], ge};
  end

  assign load = bus.start &&
                (state_q == IDLE || state_q == DONE);
  assign fin  = (state_q == RUN) &&
                (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qreg_d  = qreg_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          b_d   = bus.b;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (bus.b == '0) begin
            dz_d    = 1'b1;
            q_d     = '1;
            r_d     = a_lo;
            state_d = FLAG;
          end else if (a_hi >= bus.b) begin
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = '0;
            state_d = FLAG;
          end else begin
            rem_d   = a_hi;
            qreg_d  = a_lo;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d  = rem_nx;
        qreg_d = qreg_nx;
        cnt_d  = cnt_q + 1'b1;
        if (fin) begin
          q_d     = qreg_nx;
          r_d     = rem_nx;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      FLAG: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qreg_q  <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qreg_q  <= qreg_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DIV_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (load)
      sticky_d = (bus.b == '0) && (a_lo != '0);
    else if (fin)
      sticky_d = (rem_nx != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_q <= 1'b0;
    else
      sticky_q <= sticky_d;
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_div_48by24_seq.sv
// Directed bench for the sequential divider.
// Expected values are hand-computed quotient/remainder pairs.
module tb_div_48by24_seq;
  localparam int W = 24;
`ifdef DIV_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   bcnt;
  int   dcnt;

  div_if #(.WIDTH(W)) bus ();

  div_48by24_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2*W-1:0] av,
                          input logic [W-1:0] bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done and samples busy on the way.
  task automatic wait_done(output int c, output int bc);
    c  = 0;
    bc = 0;
    while (!bus.done && c < 100) begin
      if (bus.busy) bc++;
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [W-1:0] eq,
                         input logic [W-1:0] er,
                         input logic edz,
                         input logic eovf,
                         input logic estk);
    chk({tag, ".done"}, 48'(bus.done), 48'(1'b1));
    chk({tag, ".q"}, 48'(bus.q), 48'(eq));
    chk({tag, ".r"}, 48'(bus.r), 48'(er));
    chk({tag, ".dz"}, 48'(bus.dz), 48'(edz));
    chk({tag, ".ovf"}, 48'(bus.ovf), 48'(eovf));
    chk({tag, ".sticky"}, 48'(bus.sticky), 48'(estk));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".q"}, 48'(bus.q), 48'(0));
    chk({tag, ".r"}, 48'(bus.r), 48'(0));
    chk({tag, ".busy"}, 48'(bus.busy), 48'(0));
    chk({tag, ".done"}, 48'(bus.done), 48'(0));
    chk({tag, ".dz"}, 48'(bus.dz), 48'(0));
    chk({tag, ".ovf"}, 48'(bus.ovf), 48'(0));
    chk({tag, ".sticky"}, 48'(bus.sticky), 48'(0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7 = 14 r 2
    start_op(48'd100, 24'd7);
    wait_done(cyc, bcnt);
    chk("t1.latency", 48'(cyc), 48'(24));
    chk("t1.busycyc", 48'(bcnt), 48'(24));
    chk_res("t1", 24'h00000E, 24'h000002, 1'b0, 1'b0, STK);
    @(posedge clk);
    #1;
    chk("t1.pulse", 48'(bus.done), 48'(0));
    chk("t1.hold_q", 48'(bus.q), 48'(24'h00000E));

    // 0xFFFFFF^2 / 0xFFFFFF round trip
    start_op(48'hFFFFFE000001, 24'hFFFFFF);
    wait_done(cyc, bcnt);
    chk("t2.latency", 48'(cyc), 48'(24));
    chk_res("t2", 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b0);

    // divide by zero
    start_op(48'h000000123456, 24'h000000);
    chk("t3.early", 48'(bus.done), 48'(0));
    wait_done(cyc, bcnt);
    chk("t3.latency", 48'(cyc), 48'(1));
    chk("t3.busycyc", 48'(bcnt), 48'(0));
    chk_res("t3", 24'hFFFFFF, 24'h123456, 1'b1, 1'b0, STK);

    // quotient overflow
    start_op(48'h000001000000, 24'h000001);
    wait_done(cyc, bcnt);
    chk("t4.latency", 48'(cyc), 48'(1));
    chk("t4.busycyc", 48'(bcnt), 48'(0));
    chk_res("t4", 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0);

    // start while busy is ignored
    start_op(48'd100, 24'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 48'd50;
    bus.b     = 24'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bcnt);
    chk("t5.latency", 48'(cyc), 48'(14));
    chk_res("t5", 24'h00000E, 24'h000002, 1'b0, 1'b0, STK);

    // back-to-back start in the done cycle
    bus.start = 1'b1;
    bus.a     = 48'd50;
    bus.b     = 24'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("t6.busy", 48'(bus.busy), 48'(1));
    wait_done(cyc, bcnt);
    chk("t6.latency", 48'(cyc), 48'(24));
    chk_res("t6", 24'h00000A, 24'h000000, 1'b0, 1'b0, 1'b0);

    // reset mid-run aborts with no done pulse
    start_op(48'd100, 24'd7);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t7.abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("t7.quiet", 48'(dcnt), 48'(0));
    start_op(48'd100, 24'd7);
    wait_done(cyc, bcnt);
    chk("t7.latency", 48'(cyc), 48'(24));
    chk_res("t7", 24'h00000E, 24'h000002, 1'b0, 1'b0, STK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/div_48by24_seq.md
Name: div_48by24_seq

Overview:
- Sequential unsigned divider: 48-bit dividend ÷ 24-bit divisor → 24-bit quotient and 24-bit remainder.
- Inverse of the FPU's 24x24→48 array mantissa multiplier. Serves the FPU divide path: the dividend is the pre-shifted mantissa, the divisor is the other mantissa.
- Radix-2 restoring algorithm, one quotient bit per clock, start/busy/done handshake.

Parameters:
WIDTH, 24, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
a  input  2*WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
q  output  WIDTH  quotient; valid when done=1, held until next accepted start
r  output  WIDTH  remainder; valid/held as q
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
dz  output  1  divide-by-zero flag; valid/held as q
ovf  output  1  quotient overflow flag (a[2W-1:W] >= b, b≠0); valid/held as q
sticky  output  1  remainder non-zero; see Optional Feature

Behaviour:
- Reset (async assert, sync release): state IDLE; q, r, busy, done, dz, ovf, sticky all 0; counter 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - Register a and b; clear dz, ovf, sticky.
  - If b==0: dz=1, q=all ones, r=a[WIDTH-1:0]; go to DONE.
  - Else if a[2W-1:W] >= b: ovf=1, q=all ones, r=0; go to DONE.
  - Else: partial remainder = a[2W-1:W], quotient shift register = a[W-1:0], counter=0, busy=1; go to RUN.
  - Exception path: done=1 after edge k+1; busy stays 0.
- RUN, each edge:
  - Shift {rem, qreg} left 1 into a (W+1)-bit trial value.
  - trial = shifted_rem − b. If trial ≥ 0 (no borrow): rem=trial, new LSB=1. Else rem keeps the shifted value, new LSB=0.
  - counter+1.
  - On the edge where counter reaches WIDTH−1 (the WIDTH-th iteration): q=final qreg, r=final rem, busy=0, done=1, go to DONE.
- Latency: done high in the cycle after edge k+WIDTH (24 cycles for the default).
- DONE lasts exactly one cycle. Then IDLE with done=0, unless start=1 in the DONE cycle; that start is accepted, enabling back-to-back operation.
- start while busy=1: ignored; a/b changes have no effect on the operation in flight.
- Remainder width rule: the intermediate rem needs W+1 bits (carry out of the shift). Final r < b always fits in W bits.
- Reset mid-RUN: immediate abort to reset values; no done pulse.
- q/r/flags change only at a load edge or a completion edge.

Optional Feature:
- Macro: DIV_STICKY_EN.
- Defined:
  - sticky = (r != 0), registered with q/r at completion.
  - On dz: sticky = (a[W-1:0] != 0).
  - On ovf: sticky = 0.
  - Feeds FPU round logic.
- Undefined: sticky port present but tied to 0; no compare logic.

Test Plan:
- a=48'd100, b=24'd7, start one cycle → busy=1 for 24 cycles; done pulse after edge k+24; q=24'h00000E, r=24'h000002, dz=0, ovf=0.
- a=48'hFFFFFE000001 (0xFFFFFF²), b=24'hFFFFFF → q=24'hFFFFFF, r=0, ovf=0; multiplier round-trip check.
- b=0, a=48'h000000_123456 → done after edge k+1, dz=1, q=24'hFFFFFF, r=24'h123456, busy never 1; with DIV_STICKY_EN, sticky=1.
- a=48'h000001_000000, b=24'h000001 → ovf=1, q=24'hFFFFFF, r=0, done after edge k+1.
- Start a=100,b=7; at cycle 10 drive start=1 with a=50,b=5 → ignored; result still q=14, r=2. Then start in the DONE cycle with a=50,b=5 → accepted, q=10, r=0 after 24 more cycles.
- rst_n low during RUN cycle 12 → all outputs 0 immediately, no done. After release, a=100,b=7 → q=14, r=2; sticky=1 with DIV_STICKY_EN, 0 without. The 0xFFFFFF² case gives sticky=0 in both builds.
